sprite_asset_loader: RTL and testbench

Sequencer that streams sprite textures (bird, pipe cap, ground) from SDRAM into the sprite renderer's texture RAMs after power-up or a level reload. It issues burst reads on the SDRAM read port and re-addresses each returned word onto the renderer's three load interfaces (shared data bus, per-asset enable and address). It runs in the 50 MHz load-clock domain, the same clock as the renderer's texture write ports.

---
 rtl/sprite_asset_loader.sv | 177 +++++++++++++++++
 tb/tb_sprite_asset_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_asset_loader.sv
// Streams bird, pipe-cap and ground textures from SDRAM into the sprite renderer's texture RAMs.
// Optional: define SPRITE_LOADER_CKSUM_EN to add a 16-bit running sum of emitted words on cksum.
module sprite_asset_loader #(
    parameter logic [23:0] BIRD_BASE  = 24'h000000,
    parameter int unsigned BIRD_WORDS = 5250,
    parameter logic [23:0] PIPE_BASE  = 24'h002000,
    parameter int unsigned PIPE_WORDS = 4000,
    parameter logic [23:0] BASE_BASE  = 24'h00C000,
    parameter int unsigned BASE_WORDS = 9600,
    parameter int unsigned BURST_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        sdram_rd_req,
    output logic [23:0] sdram_rd_addr,
    output logic [8:0]  sdram_rd_len,
    input  logic        sdram_rd_ack,
    input  logic        sdram_rd_valid,
    input  logic [15:0] sdram_rd_data,
    output logic [15:0] load_data,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        base_load_en,
    output logic [13:0] base_load_addr,
    output logic        busy,
    output logic        done
`ifdef SPRITE_LOADER_CKSUM_EN
    ,
    output logic [15:0] cksum
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, DATA, NEXT, FIN} state_t;
    typedef enum logic [1:0] {A_BIRD, A_PIPE, A_BASE} asset_t;

    localparam logic [15:0] BIRD_W  = 16'(BIRD_WORDS);
    localparam logic [15:0] PIPE_W  = 16'(PIPE_WORDS);
    localparam logic [15:0] BASE_W  = 16'(BASE_WORDS);
    localparam logic [15:0] BURST_W = 16'(BURST_LEN);

    state_t      state, state_n;
    asset_t      asset;
    logic [15:0] word_cnt;
    logic [8:0]  burst_cnt;

    logic [23:0] cur_base;
    logic [15:0] cur_words;
    logic [15:0] remaining;
    logic [8:0]  cur_len;
    logic        accept;
    logic        last_word;
    logic        asset_done;

    always_comb begin
        cur_base  = BIRD_BASE;
        cur_words = BIRD_W;
        unique case (asset)
            A_PIPE: begin
                cur_base  = PIPE_BASE;
                cur_words = PIPE_W;
            end
            A_BASE: begin
                cur_base  = BASE_BASE;
                cur_words = BASE_W;
            end
            default: ;
        endcase
        remaining  = cur_words - word_cnt;
        cur_len    = (remaining > BURST_W) ? BURST_W[8:0] : remaining[8:0];
        // Words beyond the granted burst length or outside DATA are dropped here.
        accept     = (state == DATA) && sdram_rd_valid && (burst_cnt != '0);
        last_word  = accept && (burst_cnt == 9'd1);
        asset_done = (word_cnt >= cur_words);
    end

    always_comb begin
        sdram_rd_req  = (state == REQ);
        sdram_rd_addr = '0;
        sdram_rd_len  = '0;
        if (state == REQ) begin
            sdram_rd_addr = cur_base + {8'h00, word_cnt};
            sdram_rd_len  = cur_len;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = REQ;
            REQ:  if (sdram_rd_ack) state_n = DATA;
            DATA: if (last_word) state_n = NEXT;
            NEXT: state_n = (asset_done && asset == A_BASE) ? FIN : REQ;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asset          <= A_BIRD;
            word_cnt       <= '0;
            burst_cnt      <= '0;
            load_data      <= '0;
            bird_load_en   <= 1'b0;
            bird_load_addr <= '0;
            pipe_load_en   <= 1'b0;
            pipe_load_addr <= '0;
            base_load_en   <= 1'b0;
            base_load_addr <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SPRITE_LOADER_CKSUM_EN
            cksum          <= '0;
`endif
        end else begin
            bird_load_en <= 1'b0;
            pipe_load_en <= 1'b0;
            base_load_en <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    asset    <= A_BIRD;
                    word_cnt <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b1;
`ifdef SPRITE_LOADER_CKSUM_EN
                    cksum    <= '0;
`endif
                end
                REQ: if (sdram_rd_ack) burst_cnt <= cur_len;
                DATA: if (accept) begin
                    load_data <= sdram_rd_data;
                    unique case (asset)
                        A_PIPE: begin
                            pipe_load_en   <= 1'b1;
                            pipe_load_addr <= word_cnt;
                        end
                        A_BASE: begin
                            base_load_en   <= 1'b1;
                            base_load_addr <= word_cnt[13:0];
                        end
                        default: begin
                            bird_load_en   <= 1'b1;
                            bird_load_addr <= word_cnt[12:0];
                        end
                    endcase
                    word_cnt  <= word_cnt + 16'd1;
                    burst_cnt <= burst_cnt - 9'd1;
`ifdef SPRITE_LOADER_CKSUM_EN
                    cksum     <= cksum + sdram_rd_data;
`endif
                end
                NEXT: if (asset_done) begin
                    word_cnt <= '0;
                    unique case (asset)
                        A_BIRD:  asset <= A_PIPE;
                        A_PIPE:  asset <= A_BASE;
                        default: ;
                    endcase
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_asset_loader.sv
// Directed bench for sprite_asset_loader: SDRAM read-port model, strobe monitor and scenario table.
// Checks cksum as well when SPRITE_LOADER_CKSUM_EN is defined.
`timescale 1ns/1ps
module tb_sprite_asset_loader;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        req, ack, valid;
    logic [23:0] addr;
    logic [8:0]  len;
    logic [15:0] rdata, load_data;
    logic        bird_en, pipe_en, base_en, busy, done;
    logic [12:0] bird_addr;
    logic [15:0] pipe_addr;
    logic [13:0] base_addr;
`ifdef SPRITE_LOADER_CKSUM_EN
    logic [15:0] cksum;
`endif

    always #10 clk = ~clk;

    sprite_asset_loader #(
        .BIRD_BASE(24'h000000), .BIRD_WORDS(5250),
        .PIPE_BASE(24'h002000), .PIPE_WORDS(4000),
        .BASE_BASE(24'h00C000), .BASE_WORDS(9600),
        .BURST_LEN(256)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sdram_rd_req(req), .sdram_rd_addr(addr), .sdram_rd_len(len),
        .sdram_rd_ack(ack), .sdram_rd_valid(valid), .sdram_rd_data(rdata),
        .load_data(load_data),
        .bird_load_en(bird_en), .bird_load_addr(bird_addr),
        .pipe_load_en(pipe_en), .pipe_load_addr(pipe_addr),
        .base_load_en(base_en), .base_load_addr(base_addr),
        .busy(busy), .done(done)
`ifdef SPRITE_LOADER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scenario controls, written only by the main sequence.
    int unsigned m_ack_dly = 3;
    bit          m_gaps = 1'b0, m_ones = 1'b0, m_extra = 1'b0;
    int unsigned spur_req_cnt = 0;

    // SDRAM model state, written only by the model.
    int unsigned spur_done_cnt = 0;
    int unsigned nburst[3];
    logic [8:0]  last_len[3];
    logic [23:0] last_addr[3];
    int unsigned stab_err = 0, len_err = 0;

    function automatic int asset_of(input logic [23:0] a);
        if (a < 24'h002000) return 0;
        if (a < 24'h00C000) return 1;
        return 2;
    endfunction

    initial begin
        logic [23:0] a;
        logic [8:0]  l;
        int          idx;
        int          g;
        ack = 1'b0; valid = 1'b0; rdata = '0;
        for (int k = 0; k < 3; k++) begin
            nburst[k] = 0; last_len[k] = '0; last_addr[k] = '0;
        end
        forever begin
            @(posedge clk); #1;
            if (spur_req_cnt != spur_done_cnt) begin
                spur_done_cnt++;
                valid = 1'b1; rdata = 16'hDEAD;
                @(posedge clk); #1;
                valid = 1'b0;
            end else if (!rst && req) begin
                a = addr; l = len; idx = asset_of(a);
                nburst[idx]++;
                last_len[idx]  = l;
                last_addr[idx] = a;
                if (l == 9'd0 || l > 9'd256) len_err++;
                for (int i = 0; i < int'(m_ack_dly) && !rst; i++) begin
                    if (!req || addr !== a || len !== l) stab_err++;
                    @(posedge clk); #1;
                end
                if (!rst) begin
                    if (!req || addr !== a || len !== l) stab_err++;
                    ack = 1'b1;
                    @(posedge clk); #1;
                    ack = 1'b0;
                end
                for (int i = 0; i < int'(l) && !rst; i++) begin
                    if (m_gaps && $urandom_range(0, 7) == 0) begin
                        g = $urandom_range(0, 5);
                        repeat (g) @(posedge clk);
                        #1;
                    end
                    valid = 1'b1;
                    rdata = m_ones ? 16'hFFFF : 16'(a + 24'(i));
                    @(posedge clk); #1;
                    valid = 1'b0;
                end
                // One surplus word right after the burst must be dropped.
                if (m_extra && !rst) begin
                    valid = 1'b1; rdata = 16'hBEEF;
                    @(posedge clk); #1;
                    valid = 1'b0;
                end
            end
        end
    end

    // Strobe monitor, restarted by every accepted start.
    int unsigned bird_cnt = 0, pipe_cnt = 0, base_cnt = 0, data_err = 0, multi_err = 0;
    logic [15:0] sum = '0;

    function automatic logic [15:0] exp_word(input logic [23:0] base, input int unsigned k);
        logic [23:0] w;
        w = base + 24'(k);
        return m_ones ? 16'hFFFF : w[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && start && !busy) begin
            bird_cnt = 0; pipe_cnt = 0; base_cnt = 0;
            data_err = 0; multi_err = 0; sum = '0;
        end else if (!rst) begin
            if (int'(bird_en) + int'(pipe_en) + int'(base_en) > 1) multi_err++;
            if (bird_en) begin
                if (bird_addr !== 13'(bird_cnt) || load_data !== exp_word(24'h000000, bird_cnt)) data_err++;
                sum = sum + load_data; bird_cnt++;
            end
            if (pipe_en) begin
                if (pipe_addr !== 16'(pipe_cnt) || load_data !== exp_word(24'h002000, pipe_cnt)) data_err++;
                sum = sum + load_data; pipe_cnt++;
            end
            if (base_en) begin
                if (base_addr !== 14'(base_cnt) || load_data !== exp_word(24'h00C000, base_cnt)) data_err++;
                sum = sum + load_data; base_cnt++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0]  ack_dly;
        logic        gaps;
        logic        ones;
        logic        extra;
        logic [15:0] n_bird, n_pipe, n_base;
        logic [7:0]  b_bird, b_pipe, b_base;
        logic [8:0]  l_bird, l_pipe, l_base;
        logic [23:0] a_bird, a_pipe, a_base;
    } vec_t;

    vec_t        tbl[2];
    int unsigned nb0[3];
    int unsigned stab0, len0;
    int unsigned tot;

    initial begin
        tbl[0] = '{ack_dly: 8'd3, gaps: 1'b0, ones: 1'b0, extra: 1'b1,
                   n_bird: 16'd5250, n_pipe: 16'd4000, n_base: 16'd9600,
                   b_bird: 8'd21, b_pipe: 8'd16, b_base: 8'd38,
                   l_bird: 9'd130, l_pipe: 9'd160, l_base: 9'd128,
                   a_bird: 24'h001400, a_pipe: 24'h002F00, a_base: 24'h00E500};
        tbl[1] = '{ack_dly: 8'd10, gaps: 1'b1, ones: 1'b1, extra: 1'b0,
                   n_bird: 16'd5250, n_pipe: 16'd4000, n_base: 16'd9600,
                   b_bird: 8'd21, b_pipe: 8'd16, b_base: 8'd38,
                   l_bird: 9'd130, l_pipe: 9'd160, l_base: 9'd128,
                   a_bird: 24'h001400, a_pipe: 24'h002F00, a_base: 24'h00E500};

        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {req, bird_en, pipe_en, base_en, busy, done}, '0);
        check("reset_rd_addr_len", {addr, len}, '0);
        check("reset_load_data", load_data, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        spur_req_cnt = 3;
        repeat (12) @(posedge clk);
        #1;
        tot = bird_cnt + pipe_cnt + base_cnt;
        check("idle_spurious_strobes", tot, 0);
        check("idle_spurious_busy", {busy, req}, '0);

        for (int r = 0; r < 2; r++) begin
            m_ack_dly = int'(tbl[r].ack_dly);
            m_gaps    = tbl[r].gaps;
            m_ones    = tbl[r].ones;
            m_extra   = tbl[r].extra;
            for (int k = 0; k < 3; k++) nb0[k] = nburst[k];
            stab0 = stab_err; len0 = len_err;

            pulse_start();
            check($sformatf("row%0d_start_busy_done", r), {busy, done}, 2'b10);
            repeat (40) @(posedge clk);
            pulse_start();
            for (int c = 0; c < 40000 && !done; c++) begin
                @(negedge clk); #1;
            end
            check($sformatf("row%0d_done", r), {busy, done}, 2'b01);
            check($sformatf("row%0d_bird_strobes", r), bird_cnt, 32'(tbl[r].n_bird));
            check($sformatf("row%0d_pipe_strobes", r), pipe_cnt, 32'(tbl[r].n_pipe));
            check($sformatf("row%0d_base_strobes", r), base_cnt, 32'(tbl[r].n_base));
            check($sformatf("row%0d_addr_data_errors", r), data_err, 0);
            check($sformatf("row%0d_multi_enable", r), multi_err, 0);
            check($sformatf("row%0d_bird_bursts", r), nburst[0] - nb0[0], 32'(tbl[r].b_bird));
            check($sformatf("row%0d_pipe_bursts", r), nburst[1] - nb0[1], 32'(tbl[r].b_pipe));
            check($sformatf("row%0d_base_bursts", r), nburst[2] - nb0[2], 32'(tbl[r].b_base));
            check($sformatf("row%0d_bird_last_len", r), 32'(last_len[0]), 32'(tbl[r].l_bird));
            check($sformatf("row%0d_pipe_last_len", r), 32'(last_len[1]), 32'(tbl[r].l_pipe));
            check($sformatf("row%0d_base_last_len", r), 32'(last_len[2]), 32'(tbl[r].l_base));
            check($sformatf("row%0d_bird_last_addr", r), 32'(last_addr[0]), 32'(tbl[r].a_bird));
            check($sformatf("row%0d_pipe_last_addr", r), 32'(last_addr[1]), 32'(tbl[r].a_pipe));
            check($sformatf("row%0d_base_last_addr", r), 32'(last_addr[2]), 32'(tbl[r].a_base));
            check($sformatf("row%0d_req_stability", r), stab_err - stab0, 0);
            check($sformatf("row%0d_len_range", r), len_err - len0, 0);
`ifdef SPRITE_LOADER_CKSUM_EN
            check($sformatf("row%0d_cksum_vs_model", r), cksum, sum);
            if (tbl[r].ones) check($sformatf("row%0d_cksum_all_ones", r), cksum, 16'hB65E);
`endif
            repeat (5) @(posedge clk);
        end

        m_ack_dly = 3; m_gaps = 1'b0; m_ones = 1'b0; m_extra = 1'b0;
        pulse_start();
        for (int c = 0; c < 20000 && pipe_cnt < 100; c++) begin
            @(negedge clk); #1;
        end
        check("midpipe_reached", {31'd0, pipe_cnt >= 100}, 1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("midpipe_reset_ctrl", {req, bird_en, pipe_en, base_en, busy, done}, '0);
        check("midpipe_reset_rd_addr_len", {addr, len}, '0);
        check("midpipe_reset_load", {load_data, pipe_addr}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        pulse_start();
        for (int c = 0; c < 2000 && bird_cnt < 300; c++) begin
            @(negedge clk); #1;
        end
        check("reload_bird_progress", {31'd0, bird_cnt >= 300}, 1);
        check("reload_pipe_strobes", pipe_cnt, 0);
        check("reload_addr_data_errors", data_err, 0);
        check("reload_busy", {busy, done}, 2'b10);

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
